// File: rtl/cla_queue_mc.sv
// Clause lookup queue: node buffer, literal head table,
// round-robin lookup port and per-engine node read ports.
module cla_queue_mc #(
  parameter int DEPTH   = 16,
  parameter int NUM_BCP = 2,
  parameter int LIT_W   = 8,
  parameter int NODE_W  = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CH_W   = (NUM_BCP > 1) ? $clog2(NUM_BCP) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [NODE_W-1:0]         node_in,
  output logic                      full,
  output logic [PTR_W:0]            count,
  output logic                      overflow,
  input  logic                      head_we,
  input  logic [LIT_W-1:0]          head_lit,
  input  logic [PTR_W-1:0]          head_ptr,
  input  logic [NUM_BCP-1:0]        lk_req_valid,
  input  logic [NUM_BCP*LIT_W-1:0]  lk_req_lit,
  output logic [NUM_BCP-1:0]        lk_req_ready,
  output logic                      lk_rsp_valid,
  output logic [CH_W-1:0]           lk_rsp_ch,
  output logic [PTR_W-1:0]          lk_rsp_ptr,
  output logic                      lk_rsp_hit,
  output logic                      lk_rsp_err,
  input  logic [NUM_BCP-1:0]        rd_valid,
  input  logic [NUM_BCP*PTR_W-1:0]  rd_idx,
  output logic [NUM_BCP*NODE_W-1:0] rd_data,
  output logic [NUM_BCP-1:0]        rd_data_valid
);

  localparam int HT_N = 2 ** LIT_W;

  function automatic logic [LIT_W-1:0] lit_idx(
    input logic [LIT_W-1:0] lit
  );
    logic [LIT_W-1:0] v;
    v = lit[LIT_W-1] ? -lit : lit;
    return {lit[LIT_W-1], v[LIT_W-2:0]};
  endfunction

  // 0 and the most negative value both have zero magnitude bits
  function automatic logic lit_bad(
    input logic [LIT_W-1:0] lit
  );
    return lit[LIT_W-2:0] == '0;
  endfunction

  logic [NODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  hptr_q [HT_N];

  logic [HT_N-1:0]   hvld_q, hvld_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [CH_W-1:0]   rr_q, rr_d;

  logic              rsp_vld_q, rsp_vld_d;
  logic [CH_W-1:0]   rsp_ch_q, rsp_ch_d;
  logic [PTR_W-1:0]  rsp_ptr_q, rsp_ptr_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NUM_BCP*NODE_W-1:0] rdd_q, rdd_d;
  logic [NUM_BCP-1:0]        rdv_q, rdv_d;

  logic              any;
  logic              go;
  int                best;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   win_nxt;
  logic [LIT_W-1:0]  lk_lit;
  logic [LIT_W-1:0]  lk_idx;
  logic              lk_bad;
  logic              mem_we;
  logic              hd_we;
  logic [LIT_W-1:0]  hd_idx;

  assign full     = count_q == (PTR_W+1)'(DEPTH);
  assign count    = count_q;
  assign overflow = ovf_q;

  // winner is the requester closest to the priority pointer
  always_comb begin
    best   = NUM_BCP;
    win    = '0;
    lk_lit = '0;
    any    = |lk_req_valid;
    for (int c = 0; c < NUM_BCP; c++) begin
      if (lk_req_valid[c] &&
          ((c - int'(rr_q) + NUM_BCP) % NUM_BCP) < best) begin
        best = (c - int'(rr_q) + NUM_BCP) % NUM_BCP;
        win  = CH_W'(c);
      end
    end
    for (int c = 0; c < NUM_BCP; c++) begin
      if (win == CH_W'(c)) lk_lit = lk_req_lit[c*LIT_W +: LIT_W];
    end
  end

  assign go      = any && rst_n && !flush;
  assign win_nxt = (win == CH_W'(NUM_BCP - 1)) ? '0 : win + CH_W'(1);
  assign lk_req_ready = go ? (NUM_BCP'(1) << win) : '0;
  assign lk_idx  = lit_idx(lk_lit);
  assign lk_bad  = lit_bad(lk_lit);

  assign mem_we = rst_n && push && !flush && !full;
  assign hd_we  = rst_n && head_we && !flush && !lit_bad(head_lit);
  assign hd_idx = lit_idx(head_lit);

  always_comb begin
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    hvld_d    = hvld_q;
    rr_d      = rr_q;
    rsp_vld_d = go;
    rsp_ch_d  = rsp_ch_q;
    rsp_ptr_d = rsp_ptr_q;
    rsp_hit_d = rsp_hit_q;
    rsp_err_d = rsp_err_q;
    if (flush) begin
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      hvld_d  = '0;
      rr_d    = '0;
    end else begin
      if (push) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          tail_d  = tail_q + PTR_W'(1);
          count_d = count_q + (PTR_W+1)'(1);
        end
      end
      if (hd_we) hvld_d[hd_idx] = 1'b1;
      if (go) begin
        rr_d      = win_nxt;
        rsp_ch_d  = win;
        rsp_err_d = lk_bad;
        rsp_hit_d = !lk_bad && hvld_q[lk_idx];
        rsp_ptr_d = rsp_hit_d ? hptr_q[lk_idx] : '0;
      end
    end
  end

  always_comb begin
    rdd_d = '0;
    rdv_d = rd_valid;
    for (int c = 0; c < NUM_BCP; c++) begin
      rdd_d[c*NODE_W +: NODE_W] = mem_q[rd_idx[c*PTR_W +: PTR_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hvld_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rr_q      <= '0;
      rsp_vld_q <= 1'b0;
      rsp_ch_q  <= '0;
      rsp_ptr_q <= '0;
      rsp_hit_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rdd_q     <= '0;
      rdv_q     <= '0;
    end else begin
      hvld_q    <= hvld_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_ch_q  <= rsp_ch_d;
      rsp_ptr_q <= rsp_ptr_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_err_q <= rsp_err_d;
      rdd_q     <= rdd_d;
      rdv_q     <= rdv_d;
    end
  end

  // storage arrays need no reset; validity lives in hvld_q and count_q
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tail_q] <= node_in;
    if (hd_we) hptr_q[hd_idx] <= head_ptr;
  end

  assign lk_rsp_valid  = rsp_vld_q;
  assign lk_rsp_ch     = rsp_ch_q;
  assign lk_rsp_ptr    = rsp_ptr_q;
  assign lk_rsp_hit    = rsp_hit_q;
  assign lk_rsp_err    = rsp_err_q;
  assign rd_data       = rdd_q;
  assign rd_data_valid = rdv_q;

endmodule

// File: tb/tb_cla_queue_mc.sv
// Scoreboard bench for cla_queue_mc with a literal-keyed
// reference model and randomized traffic.
module tb_cla_queue_mc;
  localparam int DEPTH = 16;
  localparam int NB    = 2;
  localparam int LW    = 8;
  localparam int NW    = 32;
  localparam int PW    = 4;
  localparam int CW    = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            push = 1'b0;
  logic [NW-1:0]   node_in = '0;
  logic            full;
  logic [PW:0]     count;
  logic            overflow;
  logic            head_we = 1'b0;
  logic [LW-1:0]   head_lit = '0;
  logic [PW-1:0]   head_ptr = '0;
  logic [NB-1:0]   lk_req_valid = '0;
  logic [NB*LW-1:0] lk_req_lit = '0;
  logic [NB-1:0]   lk_req_ready;
  logic            lk_rsp_valid;
  logic [CW-1:0]   lk_rsp_ch;
  logic [PW-1:0]   lk_rsp_ptr;
  logic            lk_rsp_hit;
  logic            lk_rsp_err;
  logic [NB-1:0]   rd_valid = '0;
  logic [NB*PW-1:0] rd_idx = '0;
  logic [NB*NW-1:0] rd_data;
  logic [NB-1:0]   rd_data_valid;

  cla_queue_mc #(
    .DEPTH(DEPTH), .NUM_BCP(NB), .LIT_W(LW), .NODE_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push),
    .node_in(node_in), .full(full), .count(count),
    .overflow(overflow), .head_we(head_we),
    .head_lit(head_lit), .head_ptr(head_ptr),
    .lk_req_valid(lk_req_valid), .lk_req_lit(lk_req_lit),
    .lk_req_ready(lk_req_ready), .lk_rsp_valid(lk_rsp_valid),
    .lk_rsp_ch(lk_rsp_ch), .lk_rsp_ptr(lk_rsp_ptr),
    .lk_rsp_hit(lk_rsp_hit), .lk_rsp_err(lk_rsp_err),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int ch; int ptr; bit hit; bit err;
  } rsp_t;
  typedef struct {
    bit v; bit chk; logic [NW-1:0] d;
  } rd_t;

  rsp_t rsp_q[$];
  rd_t  rd_q[NB][$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int            m_cnt = 0;
  int            m_tail = 0;
  bit            m_ovf = 0;
  int            m_prio = 0;
  logic [NW-1:0] m_mem[DEPTH];
  bit            m_known[DEPTH];
  int            h_ptr[int];
  int            lits[9] = '{1, -1, 2, -2, 3, -3, 0, -128, 127};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int lit_val(input logic [LW-1:0] l);
    return int'($signed(l));
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    m_tail = 0;
    m_ovf = 0;
    m_prio = 0;
    h_ptr.delete();
  endtask

  task automatic cycle();
    rsp_t re;
    rd_t  rde[NB];
    int   w;
    int   l;
    int   k;
    #1;
    re = '{default: 0};
    if (rst_n && !flush && lk_req_valid != '0) begin
      w = -1;
      for (int i = 0; i < NB; i++) begin
        k = (m_prio + i) % NB;
        if (w < 0 && ((lk_req_valid >> k) & 1) != 0) w = k;
      end
      chk("grant", 64'(lk_req_ready), 64'(1 << w));
      l = lit_val(LW'(lk_req_lit >> (w * LW)));
      re.v = 1;
      re.ch = w;
      if (l == 0 || l == -128) re.err = 1;
      else if (h_ptr.exists(l)) begin
        re.hit = 1;
        re.ptr = h_ptr[l];
      end
      m_prio = (w + 1) % NB;
    end else begin
      chk("no_grant", 64'(lk_req_ready), 64'(0));
    end
    for (int c = 0; c < NB; c++) begin
      k = int'(rd_idx[c*PW +: PW]);
      rde[c].v = rst_n && rd_valid[c];
      rde[c].chk = m_known[k];
      rde[c].d = m_mem[k];
    end
    if (!rst_n) model_clear();
    else if (flush) model_clear();
    else begin
      if (push) begin
        if (m_cnt == DEPTH) m_ovf = 1;
        else begin
          m_mem[m_tail] = node_in;
          m_known[m_tail] = 1;
          m_tail = (m_tail + 1) % DEPTH;
          m_cnt++;
        end
      end
      l = lit_val(head_lit);
      if (head_we && l != 0 && l != -128) h_ptr[l] = int'(head_ptr);
    end
    @(posedge clk);
    rsp_q.push_back(re);
    for (int c = 0; c < NB; c++) rd_q[c].push_back(rde[c]);
    #1;
    chk("count", 64'(count), 64'(m_cnt));
    chk("full", 64'(full), 64'(m_cnt == DEPTH));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (!rst_n) begin
      chk("rst_ready", 64'(lk_req_ready), 64'(0));
      chk("rst_rsp", 64'({lk_rsp_valid, lk_rsp_ch, lk_rsp_ptr,
                          lk_rsp_hit, lk_rsp_err}), 64'(0));
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_rd_valid", 64'(rd_data_valid), 64'(0));
    end
  endtask

  rsp_t mr;
  rd_t  md;
  always @(negedge clk) begin
    if (rsp_q.size() > 0) begin
      mr = rsp_q.pop_front();
      chk("rsp_valid", 64'(lk_rsp_valid), 64'(mr.v));
      if (mr.v) begin
        chk("rsp_ch", 64'(lk_rsp_ch), 64'(mr.ch));
        chk("rsp_ptr", 64'(lk_rsp_ptr), 64'(mr.ptr));
        chk("rsp_hit", 64'(lk_rsp_hit), 64'(mr.hit));
        chk("rsp_err", 64'(lk_rsp_err), 64'(mr.err));
      end
    end
    for (int c = 0; c < NB; c++) begin
      if (rd_q[c].size() > 0) begin
        md = rd_q[c].pop_front();
        chk("rd_valid", 64'(rd_data_valid[c]), 64'(md.v));
        if (md.v && md.chk)
          chk("rd_data", 64'(rd_data[c*NW +: NW]), 64'(md.d));
      end
    end
  end

  task automatic idle();
    flush = 0;
    push = 0;
    node_in = '0;
    head_we = 0;
    head_lit = '0;
    head_ptr = '0;
    lk_req_valid = '0;
    lk_req_lit = '0;
    rd_valid = '0;
    rd_idx = '0;
  endtask

  task automatic req(input int c, input int lit);
    lk_req_valid[c] = 1'b1;
    lk_req_lit[c*LW +: LW] = LW'(lit);
  endtask

  task automatic rd(input int c, input int idx);
    rd_valid[c] = 1'b1;
    rd_idx[c*PW +: PW] = PW'(idx);
  endtask

  task automatic rand_cycle();
    int k;
    idle();
    flush = ($urandom_range(0, 39) == 0);
    push = ($urandom_range(0, 1) == 0);
    node_in = $urandom();
    head_we = ($urandom_range(0, 2) == 0);
    head_lit = LW'(lits[$urandom_range(0, 8)]);
    head_ptr = PW'($urandom());
    for (int c = 0; c < NB; c++) begin
      if ($urandom_range(0, 1) == 1) req(c, lits[$urandom_range(0, 8)]);
      k = $urandom_range(0, DEPTH - 1);
      if (m_known[k] && $urandom_range(0, 1) == 1) rd(c, k);
    end
    cycle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); push = 1; node_in = 32'hA000 + i; cycle();
    end
    idle(); push = 1; node_in = 32'hBEEF; cycle();
    idle(); rd(0, 0); rd(1, 15); cycle();
    idle(); flush = 1; cycle();
    idle(); cycle();
    idle(); head_we = 1; head_lit = LW'(-3); head_ptr = 5; cycle();
    idle(); req(0, -3); cycle();
    idle(); req(1, 3); cycle();
    idle(); req(0, 0); cycle();
    idle(); req(1, -128); cycle();
    for (int i = 0; i < 6; i++) begin
      idle(); req(0, -3); req(1, 5); cycle();
    end
    idle(); head_we = 1; head_lit = 7; head_ptr = 2; cycle();
    idle(); head_we = 1; head_lit = 7; head_ptr = 9; req(0, 7);
    cycle();
    idle(); req(0, 7); cycle();
    idle(); push = 1; node_in = 32'h1111; rd(0, m_tail); cycle();
    idle(); flush = 1; push = 1; node_in = 32'hDEAD;
    req(1, -3); cycle();
    idle(); req(0, -3); cycle();
    idle(); cycle();
    repeat (400) rand_cycle();
    idle(); head_we = 1; head_lit = 7; head_ptr = 3; cycle();
    idle(); push = 1; node_in = 32'h5555; req(0, 7); req(1, -3);
    rd(0, 0); rst_n = 0; cycle();
    rst_n = 1;
    idle(); req(0, 7); cycle();
    idle(); cycle();
    idle(); cycle();
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cla_queue_mc.md
# cla_queue_mc

Multi-channel clause lookup queue for the BCP lookup stage. It stores CNF clause nodes pushed by the clause arbiter into a DEPTH-entry buffer, and holds a per-literal head-pointer table with valid bits. It serves unit-clause lookups from NUM_BCP engines through a round-robin-arbitrated, registered lookup port, plus one registered node-read port per engine. It adds full/overflow tracking, flush, invalid-literal detection and per-channel handshakes.

## Interface
- DEPTH, 16: clause-node buffer entries; power of two, at least 2. PTR_W = $clog2(DEPTH).
- NUM_BCP, 2: BCP engine channels, 1..8. CH_W = max(1, $clog2(NUM_BCP)).
- LIT_W, 8: literal width in two's complement. NUM_VARS = 2^(LIT_W-1).
- NODE_W, 32: opaque clause-node width.
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  clear buffer and head table (synchronous)
- push  in  1  write node_in at tail
- node_in  in  NODE_W  clause node
- full  out  1  DEPTH nodes stored
- count  out  PTR_W+1  stored nodes
- overflow  out  1  sticky; push attempted while full
- head_we  in  1  head-table write
- head_lit  in  LIT_W  literal being written
- head_ptr  in  PTR_W  dummy-head pointer for head_lit
- lk_req_valid  in  NUM_BCP  per-channel lookup request
- lk_req_lit  in  NUM_BCP*LIT_W  per-channel literal; channel c uses bits [c*LIT_W +: LIT_W]
- lk_req_ready  out  NUM_BCP  one-hot grant
- lk_rsp_valid  out  1  lookup response valid
- lk_rsp_ch  out  CH_W  channel the response belongs to
- lk_rsp_ptr  out  PTR_W  head pointer
- lk_rsp_hit  out  1  head-table entry valid
- lk_rsp_err  out  1  literal illegal (0 or -2^(LIT_W-1))
- rd_valid  in  NUM_BCP  per-channel node read
- rd_idx  in  NUM_BCP*PTR_W  read index
- rd_data  out  NUM_BCP*NODE_W  node
- rd_data_valid  out  NUM_BCP  rd_data valid

## Operation
- Literal decode: pol = lit[LIT_W-1]; var = pol ? -lit : lit, computed in LIT_W bits. The head-table index is {pol, var[LIT_W-2:0]}, giving 2*NUM_VARS entries. Literals 0 and -2^(LIT_W-1) are illegal.
- Push: buffer[tail] <= node_in; tail and count increment; tail wraps modulo DEPTH.
  - A push while full is dropped and sets overflow. Only reset or flush clears overflow.
- Head write: when head_we is high and head_lit is legal, the entry gets head_ptr and its valid bit is set. A head write with an illegal literal is ignored.
- Lookup arbiter: round-robin among asserted lk_req_valid bits. Priority starts at channel 0 after reset or flush.
  - Exactly one lk_req_ready bit is high per cycle, and only when some request is valid. It is computed combinationally from lk_req_valid and the priority pointer.
  - After a grant, priority moves to the winner + 1, modulo NUM_BCP.
  - A request that is not granted must be held by its engine; the block keeps no request state.
- Lookup response: registered, one cycle after the grant.
  - Outputs: lk_rsp_valid = 1, lk_rsp_ch = winner, lk_rsp_ptr = entry pointer, lk_rsp_hit = entry valid bit.
  - If the literal is illegal: lk_rsp_err = 1, lk_rsp_hit = 0, lk_rsp_ptr = 0.
  - If the entry is not valid: lk_rsp_ptr = 0.
- Node read: rd_data[c] is registered from buffer[rd_idx[c]], and rd_data_valid[c] is rd_valid[c] delayed one cycle. Reads are unconditional; reading an empty slot returns stale data.
- Flush: tail = 0, count = 0, all head valid bits = 0, overflow = 0, round-robin priority = 0.
  - Flush drops any grant in the flush cycle: lk_req_ready = 0 that cycle, and lk_rsp_valid = 0 in the next cycle.
  - Buffer contents are not cleared.
- Simultaneous events:
  - flush with push or head_we: flush wins; the push and head write are dropped.
  - head_we and a lookup of the same literal in the same cycle: the lookup returns the old entry.
  - push and rd_idx equal to tail in the same cycle: the read returns the old data.

## Timing
- Reset values (rst_n = 0 at a clk edge):
  - Outputs: full = 0, count = 0, overflow = 0, lk_req_ready = 0, lk_rsp_valid = 0, lk_rsp_ch = 0, lk_rsp_ptr = 0, lk_rsp_hit = 0, lk_rsp_err = 0, rd_data = 0, rd_data_valid = 0.
  - Internal: all head valid bits = 0, tail = 0, priority = 0.
- Reset has priority over flush and every other input.
- full and count are registered and update in the cycle after a push.
- Latencies: grant to lk_rsp_valid = 1 cycle; rd_valid to rd_data_valid = 1 cycle.
- Throughput: one lookup per cycle overall; one node read per cycle per channel.
- lk_rsp_valid is a single-cycle pulse per grant. There is no back-pressure on responses.

## Test plan
- Push and full: push 16 nodes 0xA000..0xA00F, then push 0xBEEF. Required: full = 1, count = 16, overflow = 1, buffer[0] still 0xA000. Flush, then verify count = 0, full = 0, overflow = 0.
- Head lookup: head_we with lit = -3 and ptr = 5, then channel 0 looks up -3. Required: one cycle after the grant, rsp_ch = 0, ptr = 5, hit = 1. A lookup of +3 must return hit = 0, ptr = 0.
- Illegal literals: look up lit = 0 and lit = -128 with LIT_W = 8. Required: err = 1, hit = 0, ptr = 0 for both.
- Round-robin: both channels request continuously. Required: grants alternate 0, 1, 0, 1 and each lk_rsp_ch matches its grant.
- Same-cycle write and lookup: entry +7 holds 2, then head_we(+7, 9) and a lookup of +7 in the same cycle. Required: the response gives ptr = 2; a following lookup gives ptr = 9.
- Reset and flush mid-operation: assert flush while a lookup is granted and a push is active. Required: no response the next cycle, count = 0, and a subsequent lookup of a previously written literal returns hit = 0. Repeat with rst_n instead of flush and check every output reset value.
